// File: rtl/apb_master_bridge.sv
// apb_master_bridge: buffers valid/ready commands in a small FIFO and replays
// them one at a time as APB SETUP/ACCESS transfers, returning one response per
// command. A transfer whose ACCESS phase never sees pready is aborted with an
// error after TIMEOUT_CYCLES wait cycles.
module apb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pwdata_en,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Command buffer storage and bookkeeping
    logic                  r_fifo_write [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_wdata [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // FSM state and registered outputs
    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAIT_W-1:0]     r_wait;
    logic [WAIT_W-1:0]     w_wait_nxt;
    logic                  r_psel, w_psel_nxt;
    logic                  r_penable, w_penable_nxt;
    logic                  r_pwrite, w_pwrite_nxt;
    logic                  r_pwdata_en, w_pwdata_en_nxt;
    logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
    logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic                  r_rsp_write, w_rsp_write_nxt;
    logic                  r_rsp_err, w_rsp_err_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;

    logic w_push;
    logic w_pop;
    logic w_fifo_empty;

    assign cmd_ready    = (r_count != CNT_FULL);
    assign w_fifo_empty = (r_count == {CNT_W{1'b0}});
    assign w_push       = cmd_valid && cmd_ready;

    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign pwdata_en = r_pwdata_en;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

    // Command FIFO: push from the command port, pop when a transfer completes
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_write[i] <= 1'b0;
                r_fifo_addr[i]  <= {ADDR_WIDTH{1'b0}};
                r_fifo_wdata[i] <= {DATA_WIDTH{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_fifo_write[r_wr_ptr] <= cmd_write;
                r_fifo_addr[r_wr_ptr]  <= cmd_addr;
                r_fifo_wdata[r_wr_ptr] <= cmd_wdata;
                r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Next-state and next-output logic; every register holds unless changed
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_nxt      = r_wait;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_en_nxt = r_pwdata_en;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_write_nxt = r_rsp_write;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_pop           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_nxt     = ST_SETUP;
                    w_psel_nxt      = 1'b1;
                    w_penable_nxt   = 1'b0;
                    w_pwrite_nxt    = r_fifo_write[r_rd_ptr];
                    w_pwdata_en_nxt = r_fifo_write[r_rd_ptr];
                    w_paddr_nxt     = r_fifo_addr[r_rd_ptr];
                    w_pwdata_nxt    = r_fifo_wdata[r_rd_ptr];
                    w_wait_nxt      = {WAIT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                if (pready || (r_wait == WAIT_LAST)) begin
                    // Completion: normal when pready, otherwise the wait budget ran out
                    w_state_nxt     = ST_RESP;
                    w_pop           = 1'b1;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_pwdata_en_nxt = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = r_pwrite;
                    w_rsp_err_nxt   = !pready;
                    w_wait_nxt      = {WAIT_W{1'b0}};
                    if (pready && !r_pwrite) begin
                        w_rsp_rdata_nxt = prdata;
                    end else begin
                        w_rsp_rdata_nxt = {DATA_WIDTH{1'b0}};
                    end
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    if (!w_fifo_empty) begin
                        w_state_nxt     = ST_SETUP;
                        w_psel_nxt      = 1'b1;
                        w_penable_nxt   = 1'b0;
                        w_pwrite_nxt    = r_fifo_write[r_rd_ptr];
                        w_pwdata_en_nxt = r_fifo_write[r_rd_ptr];
                        w_paddr_nxt     = r_fifo_addr[r_rd_ptr];
                        w_pwdata_nxt    = r_fifo_wdata[r_rd_ptr];
                        w_wait_nxt      = {WAIT_W{1'b0}};
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_psel_nxt      = 1'b0;
                w_penable_nxt   = 1'b0;
                w_pwdata_en_nxt = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // State register and registered APB/response outputs
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wait      <= {WAIT_W{1'b0}};
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata_en <= 1'b0;
            r_paddr     <= {ADDR_WIDTH{1'b0}};
            r_pwdata    <= {DATA_WIDTH{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_wait      <= w_wait_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata_en <= w_pwdata_en_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_write <= w_rsp_write_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed protocol/timing steps followed by a
// randomized traffic phase, with responses scored against an in-order model
// that executes each command against a reference memory at push time.
module tb_apb_master_bridge;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pwdata_en, pready;
    logic [31:0] paddr, pwdata, prdata;

    int checks = 0;
    int errors = 0;

    // pready mode: 0 = always ready, 1 = random wait states, 2 = never ready
    logic [1:0] pr_mode;
    // rsp_ready mode: 0 = always, 1 = never, 2 = random
    logic [1:0] rr_mode;
    logic       pr_rnd, rr_rnd;
    logic       mem_init;

    logic [31:0] slave_mem [256];
    logic [31:0] ref_mem   [256];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] setup_q[$];

    apb_master_bridge dut (
        .pclk(pclk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pwdata_en(pwdata_en), .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    assign pready    = (pr_mode == 2'd0) || ((pr_mode == 2'd1) && pr_rnd);
    assign rsp_ready = (rr_mode == 2'd0) || ((rr_mode == 2'd2) && rr_rnd);
    assign prdata    = slave_mem[paddr[7:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Fresh random bits for the handshake inputs, changed away from the edge
    always @(posedge pclk) begin
        #1;
        pr_rnd = ($urandom_range(0, 3) != 0);
        rr_rnd = ($urandom_range(0, 1) == 1);
    end

    // APB slave memory, initialised to its index
    always @(posedge pclk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) slave_mem[i] <= 32'(i);
        end else if (psel && penable && pready && pwrite) begin
            slave_mem[paddr[7:0]] <= pwdata;
        end
    end

    // Reference model and scoreboard, sampled on the falling edge
    always @(negedge pclk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
        end
        if (rst_n) begin
            if (cmd_valid && cmd_ready) begin
                exp_t e;
                e.w   = cmd_write;
                e.a   = cmd_addr;
                e.err = (pr_mode == 2'd2);
                if (e.err) begin
                    e.rd = 32'd0;
                end else if (cmd_write) begin
                    e.rd = 32'd0;
                    ref_mem[cmd_addr[7:0]] = cmd_wdata;
                end else begin
                    e.rd = ref_mem[cmd_addr[7:0]];
                end
                exp_q.push_back(e);
            end
            if (psel && !penable) setup_q.push_back(paddr);
            if (psel) chk("pwdata_en_dir", pwdata_en, pwrite);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_write", rsp_write, e.w);
                    chk("sb_rdata", rsp_rdata, e.rd);
                    chk("sb_err", rsp_err, e.err);
                    if (setup_q.size() == 0) begin
                        chk("sb_no_setup", 64'(setup_q.size()), 64'd1);
                    end else begin
                        chk("sb_addr", setup_q.pop_front(), e.a);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(negedge pclk);
        while (!cmd_ready && n < 200) begin
            @(negedge pclk);
            n++;
        end
        if (!cmd_ready) chk("push_accept", cmd_ready, 1'b1);
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!rsp_valid && n < 100);
        chk(tag, rsp_valid, 1'b1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge pclk);
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
        repeat (2) begin @(posedge pclk); #1; end
    endtask

    initial begin
        int acc_cycles;
        int seen;
        rst_n = 1'b0; mem_init = 1'b1; pr_mode = 2'd0; rr_mode = 2'd0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
        #3;
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_pwdata_en", pwdata_en, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        repeat (3) @(posedge pclk);
        #1; mem_init = 1'b0; rst_n = 1'b1;
        @(posedge pclk); #1;

        // Reset-content read
        push(1'b0, 32'h05, 32'd0);
        wait_rsp("rd5_seen");
        chk("rd5_rdata", rsp_rdata, 32'h5);
        drain("rd5_drain");

        // Single write: exact SETUP/ACCESS timing
        push(1'b1, 32'h10, 32'hCAFE0001);
        @(negedge pclk);
        chk("wr_psel_before", psel, 1'b0);
        @(negedge pclk);
        chk("wr_setup_psel", psel, 1'b1);
        chk("wr_setup_penable", penable, 1'b0);
        chk("wr_setup_pwdata_en", pwdata_en, 1'b1);
        chk("wr_setup_paddr", paddr, 32'h10);
        chk("wr_setup_pwdata", pwdata, 32'hCAFE0001);
        @(negedge pclk);
        chk("wr_access_psel", psel, 1'b1);
        chk("wr_access_penable", penable, 1'b1);
        chk("wr_access_pwdata_en", pwdata_en, 1'b1);
        @(negedge pclk);
        chk("wr_rsp_valid", rsp_valid, 1'b1);
        chk("wr_rsp_write", rsp_write, 1'b1);
        chk("wr_rsp_err", rsp_err, 1'b0);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);
        chk("wr_rsp_psel", psel, 1'b0);
        drain("wr_drain");

        // Read after write
        push(1'b0, 32'h10, 32'hFFFFFFFF);
        wait_rsp("raw_seen");
        chk("raw_rdata", rsp_rdata, 32'hCAFE0001);
        chk("raw_write", rsp_write, 1'b0);
        drain("raw_drain");

        // FIFO full under response backpressure
        rr_mode = 2'd1;
        push(1'b0, 32'h30, 32'd0);
        push(1'b0, 32'h31, 32'd0);
        push(1'b0, 32'h32, 32'd0);
        @(negedge pclk);
        chk("full_cmd_ready", cmd_ready, 1'b0);
        chk("full_rsp_valid", rsp_valid, 1'b1);
        repeat (3) @(negedge pclk);
        chk("full_hold_valid", rsp_valid, 1'b1);
        chk("full_hold_rdata", rsp_rdata, 32'h30);
        chk("full_hold_ready", cmd_ready, 1'b0);
        @(posedge pclk); #1;
        rr_mode = 2'd0;
        drain("full_drain");

        // Timeout: ACCESS lasts exactly 16 cycles
        pr_mode = 2'd2;
        push(1'b0, 32'h40, 32'd0);
        acc_cycles = 0;
        for (int n = 0; n < 100 && !rsp_valid; n++) begin
            @(negedge pclk);
            if (penable) acc_cycles++;
        end
        chk("to_rsp_seen", rsp_valid, 1'b1);
        chk("to_access_len", 64'(acc_cycles), 64'd16);
        chk("to_err", rsp_err, 1'b1);
        chk("to_rdata", rsp_rdata, 32'd0);
        chk("to_psel", psel, 1'b0);
        drain("to_drain");
        pr_mode = 2'd0;
        push(1'b0, 32'h40, 32'd0);
        wait_rsp("to_next_seen");
        chk("to_next_err", rsp_err, 1'b0);
        chk("to_next_rdata", rsp_rdata, 32'h40);
        drain("to_next_drain");

        // Reset in the middle of ACCESS with one command queued
        pr_mode = 2'd2;
        push(1'b0, 32'h41, 32'd0);
        push(1'b0, 32'h42, 32'd0);
        for (int n = 0; n < 20 && !penable; n++) @(negedge pclk);
        chk("mid_penable_reached", penable, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_psel", psel, 1'b0);
        chk("mid_penable", penable, 1'b0);
        chk("mid_cmd_ready", cmd_ready, 1'b1);
        chk("mid_rsp_valid", rsp_valid, 1'b0);
        exp_q.delete();
        setup_q.delete();
        pr_mode = 2'd0;
        repeat (2) @(posedge pclk);
        #1; rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge pclk);
            if (rsp_valid || psel) seen++;
        end
        chk("mid_no_activity", 64'(seen), 64'd0);
        chk("mid_ready_after", cmd_ready, 1'b1);
        @(posedge pclk); #1;

        // Randomized traffic with random wait states and response backpressure
        pr_mode = 2'd1;
        rr_mode = 2'd2;
        for (int k = 0; k < 40; k++) begin
            push(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge pclk); #1; end
        end
        rr_mode = 2'd0;
        drain("rand_drain");
        pr_mode = 2'd0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
